// File: rtl/video_pattern_gen.sv
// Test-pattern source: walks a Width x Height raster and emits one {R,G,B} pixel per accepted transfer.
// One output register stage; Video/markers hold while VideoValid && !VideoReady; VideoValid stays high once out of reset.
module video_pattern_gen #(
  parameter int Width       = 1040,
  parameter int Height      = 666,
  parameter int ChannelBits = 8,
  parameter int CheckerLog2 = 5,
  parameter int RampShift   = 2
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic [2:0]               Mode,
  input  logic [3*ChannelBits-1:0] SolidColor,
  output logic [3*ChannelBits-1:0] Video,
  output logic                     VideoValid,
  input  logic                     VideoReady,
  output logic                     FrameStart,
  output logic                     LineEnd
);

  localparam int XW     = $clog2(Width);
  localparam int YW     = $clog2(Height);
  localparam int BarLen = Width / 8;
  localparam int BW     = $clog2(BarLen + 1);
  localparam int FW     = CheckerLog2 + 1;
  localparam int PW     = 3 * ChannelBits;

  localparam logic [XW-1:0] XLast   = XW'(Width - 1);
  localparam logic [YW-1:0] YLast   = YW'(Height - 1);
  localparam logic [BW-1:0] BarLast = BW'(BarLen - 1);

  typedef logic [ChannelBits-1:0] chan_t;
  localparam chan_t ChOn = '1;

  // Coordinates of the pixel that the next load will produce.
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [BW-1:0] bar_cnt_q;
  logic [2:0]    bar_idx_q;
  logic [FW-1:0] frame_q;
  logic [2:0]    mode_q;

  logic          load;
  logic          first_px;
  logic          last_x;
  logic          last_y;
  logic [2:0]    mode_eff;
  logic [FW-1:0] scroll_x;
  logic          chk_on;
  logic          scroll_on;
  chan_t         ramp_x;
  chan_t         ramp_y;
  logic [PW-1:0] pix;

  assign load     = !VideoValid || VideoReady;
  assign first_px = (x_q == '0) && (y_q == '0);
  assign last_x   = (x_q == XLast);
  assign last_y   = (y_q == YLast);
  // The frame's first pixel already uses the newly selected mode.
  assign mode_eff = first_px ? Mode : mode_q;

  assign scroll_x  = x_q[CheckerLog2:0] + frame_q;
  assign chk_on    = x_q[CheckerLog2] ^ y_q[CheckerLog2];
  assign scroll_on = scroll_x[CheckerLog2] ^ y_q[CheckerLog2];
  assign ramp_x    = ChannelBits'(x_q >> RampShift);
  assign ramp_y    = ChannelBits'(y_q >> RampShift);

  always_comb begin
    pix = '0;
    case (mode_eff)
      3'd0: pix = SolidColor;
      // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
      3'd1: pix = {{ChannelBits{~bar_idx_q[1]}}, {ChannelBits{~bar_idx_q[2]}},
                   {ChannelBits{~bar_idx_q[0]}}};
      3'd2: pix = chk_on ? {ChOn, ChOn, ChOn} : '0;
      3'd3: pix = {ramp_x, ramp_x, ramp_x};
      3'd4: pix = {ramp_y, ramp_y, ramp_y};
      3'd5: pix = scroll_on ? {ChOn, ChOn, ChOn} : '0;
      default: pix = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Video      <= '0;
      VideoValid <= 1'b0;
      FrameStart <= 1'b0;
      LineEnd    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      bar_cnt_q  <= '0;
      bar_idx_q  <= '0;
      frame_q    <= '0;
      mode_q     <= '0;
    end else if (load) begin
      Video      <= pix;
      VideoValid <= 1'b1;
      FrameStart <= first_px;
      LineEnd    <= last_x;
      if (first_px) begin
        mode_q <= Mode;
      end
      if (last_x) begin
        x_q       <= '0;
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
        if (last_y) begin
          y_q <= '0;
          // Bumped on the frame's final pixel so every pixel of a frame shares one offset.
          frame_q <= frame_q + 1'b1;
        end else begin
          y_q <= y_q + 1'b1;
        end
      end else begin
        x_q <= x_q + 1'b1;
        if (bar_cnt_q == BarLast) begin
          bar_cnt_q <= '0;
          bar_idx_q <= bar_idx_q + 1'b1;
        end else begin
          bar_cnt_q <= bar_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
